controlador_jogada: RTL and testbench

//   Control unit for the ultimate tic-tac-toe game: sequences one full turn (macro-board

---
 rtl/jogo_pkg.sv | 55 +++++
 rtl/detector_jogada.sv | 21 ++
 rtl/controlador_jogada.sv | 102 ++++++++++
 tb/tb_controlador_jogada.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/jogo_pkg.sv
// Shared encodings for the ultimate tic-tac-toe control path.
// Holds FSM state codes, player values and the registered strobe bundle.
package jogo_pkg;

  localparam int LARGURA_TABULEIRO = 9;

  localparam logic JOGADOR_X = 1'b0;
  localparam logic JOGADOR_O = 1'b1;

  typedef enum logic [3:0] {
    INICIAL      = 4'h0,
    PREPARA      = 4'h1,
    ESPERA_MACRO = 4'h2,
    REG_MACRO    = 4'h3,
    VALIDA_MACRO = 4'h4,
    ESPERA_MICRO = 4'h5,
    REG_MICRO    = 4'h6,
    VALIDA_MICRO = 4'h7,
    ESCREVE      = 4'h8,
    VERIFICA     = 4'h9,
    TROCA        = 4'hA,
    DESTINO      = 4'hB,
    FIM          = 4'hE,
    FIM_TIMEOUT  = 4'hF
  } estado_t;

  typedef struct packed {
    logic zera_regs;
    logic registra_macro;
    logic carrega_macro_destino;
    logic registra_micro;
    logic escreve_jogada;
    logic jogar_macro;
    logic jogar_micro;
    logic pronto;
    logic timeout;
  } saidas_t;

  // Moore decode: every strobe is a pure function of the state it is asserted in.
  function automatic saidas_t decodifica(estado_t e);
    saidas_t s;
    s                       = '0;
    s.zera_regs             = (e == PREPARA);
    s.registra_macro        = (e == REG_MACRO);
    s.carrega_macro_destino = (e == DESTINO);
    s.registra_micro        = (e == REG_MICRO);
    s.escreve_jogada        = (e == ESCREVE);
    s.jogar_macro           = (e == ESPERA_MACRO);
    s.jogar_micro           = (e == ESPERA_MICRO);
    s.pronto                = (e == FIM) || (e == FIM_TIMEOUT);
    s.timeout               = (e == FIM_TIMEOUT);
    return s;
  endfunction

endpackage

// File: rtl/detector_jogada.sv
// Play detector: one-cycle pulse when the buttons go from all-released to any pressed.
// Holding a button never retriggers; the previous-cycle sample is the only state.
module detector_jogada
  import jogo_pkg::*;
(
  input  logic                         clock,
  input  logic                         reset,
  input  logic [LARGURA_TABULEIRO-1:0] botoes,
  output logic                         tem_jogada
);

  logic [LARGURA_TABULEIRO-1:0] botoes_d;

  always_ff @(posedge clock) begin
    if (reset) botoes_d <= '0;
    else       botoes_d <= botoes;
  end

  assign tem_jogada = (|botoes) & ~(|botoes_d);

endmodule

// File: rtl/controlador_jogada.sv
// Turn sequencer for ultimate tic-tac-toe: drives datapath strobes, swaps players,
// and ends the game on a win/draw or when a turn exceeds TIMEOUT_CICLOS cycles.
module controlador_jogada
  import jogo_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = 5000
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         iniciar,
  input  logic [LARGURA_TABULEIRO-1:0] botoes,
  input  logic                         macro_finalizado,
  input  logic                         celula_ocupada,
  input  logic                         fim_jogo,
  input  logic                         macro_destino_livre,
  output logic                         zera_regs,
  output logic                         registra_macro,
  output logic                         carrega_macro_destino,
  output logic                         registra_micro,
  output logic                         escreve_jogada,
  output logic                         jogador,
  output logic                         jogar_macro,
  output logic                         jogar_micro,
  output logic                         pronto,
  output logic                         timeout,
  output logic                         db_tem_jogada,
  output logic [3:0]                   db_estado
);

  localparam int LARGURA_CONT = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [LARGURA_CONT-1:0] CONT_MAX = LARGURA_CONT'(TIMEOUT_CICLOS - 1);

  estado_t                 estado, prox_estado;
  saidas_t                 saidas;
  logic [LARGURA_CONT-1:0] contador;
  logic                    tem_jogada, esperando, expirou;

  detector_jogada u_detector (
    .clock      (clock),
    .reset      (reset),
    .botoes     (botoes),
    .tem_jogada (tem_jogada)
  );

  assign esperando = (estado == ESPERA_MACRO) || (estado == ESPERA_MICRO);
  assign expirou   = esperando && (contador == CONT_MAX);

  // A play arriving on the expiry cycle takes priority over the timeout.
  always_comb begin
    prox_estado = estado;
    case (estado)
      INICIAL:      if (iniciar) prox_estado = PREPARA;
      PREPARA:      prox_estado = ESPERA_MACRO;
      ESPERA_MACRO: if (tem_jogada) prox_estado = REG_MACRO;
                    else if (expirou) prox_estado = FIM_TIMEOUT;
      REG_MACRO:    prox_estado = VALIDA_MACRO;
      VALIDA_MACRO: prox_estado = macro_finalizado ? ESPERA_MACRO : ESPERA_MICRO;
      ESPERA_MICRO: if (tem_jogada) prox_estado = REG_MICRO;
                    else if (expirou) prox_estado = FIM_TIMEOUT;
      REG_MICRO:    prox_estado = VALIDA_MICRO;
      VALIDA_MICRO: prox_estado = celula_ocupada ? ESPERA_MICRO : ESCREVE;
      ESCREVE:      prox_estado = VERIFICA;
      VERIFICA:     prox_estado = fim_jogo ? FIM : TROCA;
      TROCA:        prox_estado = macro_destino_livre ? DESTINO : ESPERA_MACRO;
      DESTINO:      prox_estado = ESPERA_MICRO;
      FIM, FIM_TIMEOUT: if (iniciar) prox_estado = PREPARA;
      default:      prox_estado = INICIAL;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado    <= INICIAL;
      saidas    <= '0;
      db_estado <= 4'h0;
      jogador   <= JOGADOR_X;
      contador  <= '0;
    end else begin
      estado    <= prox_estado;
      saidas    <= decodifica(prox_estado);
      db_estado <= prox_estado;
      if (estado == PREPARA)    jogador <= JOGADOR_X;
      else if (estado == TROCA) jogador <= ~jogador;
      // Budget is per turn: invalid retries keep consuming it until the player swap.
      if ((estado == PREPARA) || (estado == TROCA)) contador <= '0;
      else if (esperando && (contador != CONT_MAX)) contador <= contador + 1'b1;
    end
  end

  assign zera_regs             = saidas.zera_regs;
  assign registra_macro        = saidas.registra_macro;
  assign carrega_macro_destino = saidas.carrega_macro_destino;
  assign registra_micro        = saidas.registra_micro;
  assign escreve_jogada        = saidas.escreve_jogada;
  assign jogar_macro           = saidas.jogar_macro;
  assign jogar_micro           = saidas.jogar_micro;
  assign pronto                = saidas.pronto;
  assign timeout               = saidas.timeout;
  assign db_tem_jogada         = tem_jogada;

endmodule

// File: tb/tb_controlador_jogada.sv
// Bench for controlador_jogada: directed turn scenarios plus random stimulus,
// all checked cycle by cycle against a rule-table reference of the turn sequence.
module tb_controlador_jogada;

  localparam int T = 20;

  logic       clock = 1'b0;
  logic       reset, iniciar;
  logic [8:0] botoes;
  logic       macro_finalizado, celula_ocupada, fim_jogo, macro_destino_livre;
  logic       zera_regs, registra_macro, carrega_macro_destino, registra_micro;
  logic       escreve_jogada, jogador, jogar_macro, jogar_micro, pronto, timeout;
  logic       db_tem_jogada;
  logic [3:0] db_estado;
  logic [8:0] saidas_dut;

  int n_ok = 0, n_total = 0;
  int n_rm = 0, n_rmi = 0, n_esc = 0, n_tem = 0;

  // reference model: spec state code, player, cycles used this turn, previous press level
  int m_est = 0, m_cnt = 0;
  bit m_jog = 0, m_bd = 0, m_valido = 0;

  always #5 clock = ~clock;

  controlador_jogada #(.TIMEOUT_CICLOS(T)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .botoes(botoes),
    .macro_finalizado(macro_finalizado), .celula_ocupada(celula_ocupada),
    .fim_jogo(fim_jogo), .macro_destino_livre(macro_destino_livre),
    .zera_regs(zera_regs), .registra_macro(registra_macro),
    .carrega_macro_destino(carrega_macro_destino), .registra_micro(registra_micro),
    .escreve_jogada(escreve_jogada), .jogador(jogador), .jogar_macro(jogar_macro),
    .jogar_micro(jogar_micro), .pronto(pronto), .timeout(timeout),
    .db_tem_jogada(db_tem_jogada), .db_estado(db_estado)
  );

  assign saidas_dut = {zera_regs, registra_macro, carrega_macro_destino, registra_micro,
                       escreve_jogada, jogar_macro, jogar_micro, pronto, timeout};

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_total++;
    if (obs === esp) n_ok++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, esp, $time);
  endtask

  // Turn rules as a lookup on the documented state codes.
  function automatic int prox(int s, bit ini, bit tem, bit exp, bit mf, bit co, bit fj, bit mdl);
    case (s)
      0:       return ini ? 1 : 0;
      1:       return 2;
      2:       return tem ? 3 : (exp ? 15 : 2);
      3:       return 4;
      4:       return mf ? 2 : 5;
      5:       return tem ? 6 : (exp ? 15 : 5);
      6:       return 7;
      7:       return co ? 5 : 8;
      8:       return 9;
      9:       return fj ? 14 : 10;
      10:      return mdl ? 11 : 2;
      11:      return 5;
      14, 15:  return ini ? 1 : s;
      default: return 0;
    endcase
  endfunction

  function automatic logic [8:0] saida_esp(int s);
    return {s == 1, s == 3, s == 11, s == 6, s == 8, s == 2, s == 5, s >= 14, s == 15};
  endfunction

  task automatic ciclo();
    bit tem, exp;
    int ns;
    #1;
    tem = (|botoes) && !m_bd;
    if (m_valido) verifica("tem_jogada", db_tem_jogada, tem);
    if (db_tem_jogada === 1'b1) n_tem++;
    exp = ((m_est == 2) || (m_est == 5)) && (m_cnt == T - 1);
    if (reset) begin
      m_est = 0; m_jog = 0; m_cnt = 0; m_bd = 0; m_valido = 1;
    end else begin
      ns = prox(m_est, iniciar, tem, exp, macro_finalizado, celula_ocupada, fim_jogo,
                macro_destino_livre);
      if (m_est == 1 || m_est == 10) m_cnt = 0;
      else if ((m_est == 2 || m_est == 5) && m_cnt < T - 1) m_cnt++;
      if (m_est == 1) m_jog = 0;
      else if (m_est == 10) m_jog = !m_jog;
      m_bd  = |botoes;
      m_est = ns;
    end
    @(posedge clock);
    #1;
    if (m_valido) begin
      verifica("db_estado", db_estado, m_est);
      verifica("jogador", jogador, m_jog);
      verifica("saidas", saidas_dut, saida_esp(m_est));
    end
    if (registra_macro === 1'b1) n_rm++;
    if (registra_micro === 1'b1) n_rmi++;
    if (escreve_jogada === 1'b1) n_esc++;
  endtask

  task automatic aplica(input bit r, input bit ini, input logic [8:0] b,
                        input bit mf, input bit co, input bit fj, input bit mdl);
    reset = r; iniciar = ini; botoes = b;
    macro_finalizado = mf; celula_ocupada = co; fim_jogo = fj; macro_destino_livre = mdl;
    ciclo();
  endtask

  initial begin
    int r;
    reset = 1; iniciar = 0; botoes = '0;
    macro_finalizado = 0; celula_ocupada = 0; fim_jogo = 0; macro_destino_livre = 0;

    // reset, then start a game
    aplica(1, 0, 9'h000, 0, 0, 0, 0);
    verifica("rst_estado", db_estado, 0);
    verifica("rst_saidas", saidas_dut, 0);
    repeat (5) aplica(0, 1, 9'h000, 0, 0, 0, 0);
    verifica("ini_jogar_macro", jogar_macro, 1);
    verifica("ini_jogador", jogador, 0);

    // one full turn ending the game
    n_rm = 0; n_rmi = 0; n_esc = 0;
    repeat (2) aplica(0, 0, 9'b000001000, 0, 0, 0, 0);
    aplica(0, 0, 9'h000, 0, 0, 0, 0);
    repeat (2) aplica(0, 0, 9'b000010000, 0, 0, 0, 0);
    aplica(0, 0, 9'h000, 0, 0, 0, 0);
    aplica(0, 0, 9'h000, 0, 0, 0, 0);
    aplica(0, 0, 9'h000, 0, 0, 1, 0);
    verifica("fim_registra_macro", n_rm, 1);
    verifica("fim_registra_micro", n_rmi, 1);
    verifica("fim_escreve", n_esc, 1);
    verifica("fim_pronto", pronto, 1);
    verifica("fim_estado", db_estado, 4'hE);

    // invalid macro and occupied cell send the player back
    aplica(0, 1, 9'h000, 0, 0, 0, 0);
    aplica(0, 0, 9'h000, 0, 0, 0, 0);
    aplica(0, 0, 9'h001, 1, 0, 0, 0);
    repeat (2) aplica(0, 0, 9'h000, 1, 0, 0, 0);
    verifica("macro_finalizado_volta", db_estado, 2);
    aplica(0, 0, 9'h002, 0, 0, 0, 0);
    repeat (2) aplica(0, 0, 9'h000, 0, 0, 0, 0);
    verifica("macro_ok", db_estado, 5);
    aplica(0, 0, 9'h004, 0, 1, 0, 0);
    repeat (2) aplica(0, 0, 9'h000, 0, 1, 0, 0);
    verifica("celula_ocupada_volta", db_estado, 5);

    // turn with free destination board, then without
    aplica(0, 0, 9'h004, 0, 0, 0, 0);
    repeat (4) aplica(0, 0, 9'h000, 0, 0, 0, 0);
    aplica(0, 0, 9'h000, 0, 0, 0, 1);
    verifica("destino_carrega", carrega_macro_destino, 1);
    verifica("destino_jogador", jogador, 1);
    aplica(0, 0, 9'h000, 0, 0, 0, 0);
    verifica("destino_micro", db_estado, 5);
    aplica(0, 0, 9'h008, 0, 0, 0, 0);
    repeat (4) aplica(0, 0, 9'h000, 0, 0, 0, 0);
    aplica(0, 0, 9'h000, 0, 0, 0, 0);
    verifica("troca_macro", db_estado, 2);
    verifica("troca_jogador", jogador, 0);

    // turn timeout, then a play landing exactly on the expiry cycle
    repeat (T) aplica(0, 0, 9'h000, 0, 0, 0, 0);
    verifica("to_timeout", timeout, 1);
    verifica("to_pronto", pronto, 1);
    verifica("to_estado", db_estado, 4'hF);
    aplica(0, 1, 9'h000, 0, 0, 0, 0);
    aplica(0, 0, 9'h000, 0, 0, 0, 0);
    repeat (T - 1) aplica(0, 0, 9'h000, 0, 0, 0, 0);
    aplica(0, 0, 9'h001, 0, 0, 0, 0);
    verifica("limite_estado", db_estado, 3);
    verifica("limite_timeout", timeout, 0);

    // held button, then reset in the middle of a turn
    aplica(1, 0, 9'h000, 0, 0, 0, 0);
    aplica(0, 1, 9'h000, 0, 0, 0, 0);
    aplica(0, 0, 9'h000, 0, 0, 0, 0);
    n_tem = 0;
    repeat (10) aplica(0, 0, 9'h100, 0, 0, 0, 0);
    verifica("segurado_pulsos", n_tem, 1);
    verifica("segurado_estado", db_estado, 5);
    aplica(0, 0, 9'h000, 0, 0, 0, 0);
    aplica(0, 0, 9'h001, 0, 0, 0, 0);
    aplica(0, 0, 9'h000, 0, 0, 0, 0);
    verifica("pre_reset_estado", db_estado, 7);
    aplica(1, 0, 9'h000, 0, 0, 0, 0);
    verifica("reset_meio_estado", db_estado, 0);
    verifica("reset_meio_saidas", saidas_dut, 0);

    // random play
    for (int i = 0; i < 3000; i++) begin
      reset   = ($urandom_range(0, 199) == 0);
      iniciar = ($urandom_range(0, 7) == 0);
      r = $urandom_range(0, 9);
      if (r < 3)      botoes = 9'($urandom_range(1, 511));
      else if (r < 6) botoes = '0;
      macro_finalizado    = 1'($urandom_range(0, 1));
      celula_ocupada      = 1'($urandom_range(0, 1));
      fim_jogo            = ($urandom_range(0, 5) == 0);
      macro_destino_livre = 1'($urandom_range(0, 1));
      ciclo();
    end

    $display("%0d/%0d checks passed", n_ok, n_total);
    $finish;
  end

endmodule
